// File: rtl/vga_frame_server.sv
// -----------------------------------------------------------------------------
// vga_frame_server
//
// Pixel source for the VGA display timing unit. Holds two 160x120 banks of
// 12-bit colour. The display reads the front bank through a combinational
// row/col/rdn port, with each source pixel replicated 4x4 to fill 640x480.
// The CPU writes single pixels or bulk-clears the back bank, and may request
// a front/back swap, which is only carried out at end of frame so a
// half-drawn image is never shown.
//
// Handshake: wr_req is a level held by the requester until wr_ack. wr_ack is
// a single-cycle pulse in the cycle after the write is committed; the
// following cycle is a dead cycle in which wr_req is ignored, so a request
// still held while the requester reacts to wr_ack is never accepted twice.
// clear_req is sampled only in IDLE and wins over wr_req; while a clear runs
// (busy=1) both requests stall without acknowledgement.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   row, col, rdn     display read address (row 0..479, col 0..639), read
//                     strobe active low
//   pix               colour {B,G,R}, combinational, 0 when not reading
//   wr_req/x/y/data   CPU pixel write request into the back bank
//   wr_ack            one-cycle write-accepted pulse
//   wr_err            sticky out-of-range write flag
//   clear_req         fill back bank with clear_color
//   busy, clear_done  clear in progress / one-cycle completion pulse
//   swap_req          one-cycle swap request pulse
//   swap_done         one-cycle pulse in the cycle after a swap
// -----------------------------------------------------------------------------
module vga_frame_server #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int SCALE_SH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  row,
  input  logic [9:0]  col,
  input  logic        rdn,
  output logic [11:0] pix,
  input  logic        wr_req,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [11:0] wr_data,
  output logic        wr_ack,
  output logic        wr_err,
  input  logic        clear_req,
  input  logic [11:0] clear_color,
  output logic        busy,
  output logic        clear_done,
  input  logic        swap_req,
  output logic        swap_done
);

  localparam int DEPTH  = FB_W * FB_H;
  localparam int AW     = $clog2(DEPTH);
  localparam int DISP_W = FB_W << SCALE_SH;
  localparam int DISP_H = FB_H << SCALE_SH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACK   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]    state;
  logic          front;
  logic          swap_pending;
  logic [AW-1:0] clr_addr;
  logic [11:0]   clr_color;
  logic          rdn_d;
  logic [8:0]    row_d;
  logic [9:0]    col_d;

  logic [11:0] bank0 [DEPTH];
  logic [11:0] bank1 [DEPTH];

  // ---------------------------------------------------------------------------
  // Display read path: asynchronous lookup in the front bank.
  // ---------------------------------------------------------------------------
  logic          rd_valid;
  logic [AW-1:0] rd_addr;

  assign rd_valid = ~rdn & (32'(row) < DISP_H) & (32'(col) < DISP_W);
  assign rd_addr  = AW'(32'(row >> SCALE_SH) * FB_W + 32'(col >> SCALE_SH));
  assign pix      = !rd_valid ? 12'h000 : (front ? bank1[rd_addr] : bank0[rd_addr]);

  // ---------------------------------------------------------------------------
  // CPU write path into the back bank (~front).
  // ---------------------------------------------------------------------------
  logic          wr_in_range;
  logic          wr_accept;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_wdata;

  assign wr_in_range = (32'(wr_x) < FB_W) & (32'(wr_y) < FB_H);
  assign wr_accept   = (state == ST_IDLE) & ~clear_req & wr_req;
  // Gated by rst so a reset landing mid-clear leaves the bank untouched
  // from that edge onwards.
  assign mem_we      = ~rst & ((wr_accept & wr_in_range) | (state == ST_CLEAR));
  assign mem_addr    = (state == ST_CLEAR) ? clr_addr
                                           : AW'(32'(wr_y) * FB_W + 32'(wr_x));
  assign mem_wdata   = (state == ST_CLEAR) ? clr_color : wr_data;

  // The bank is chosen from the pre-swap front, so a write on the swap edge
  // lands in what becomes the new front bank.
  always_ff @(posedge clk) begin
    if (mem_we && front)  bank0[mem_addr] <= mem_wdata;
    if (mem_we && !front) bank1[mem_addr] <= mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Frame end: first non-read cycle right after the last visible pixel.
  // ---------------------------------------------------------------------------
  logic fe;
  logic swap_fire;

  assign fe = rdn & ~rdn_d & (row_d == 9'(DISP_H - 1)) & (col_d == 10'(DISP_W - 1));
  // A swap during a clear would expose a half-filled bank; it waits for the
  // next frame end with the request still pending.
  assign swap_fire = fe & swap_pending & (state != ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Control FSM and swap bookkeeping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      front        <= 1'b0;
      swap_pending <= 1'b0;
      wr_ack       <= 1'b0;
      wr_err       <= 1'b0;
      busy         <= 1'b0;
      clear_done   <= 1'b0;
      swap_done    <= 1'b0;
      clr_addr     <= '0;
      clr_color    <= 12'h000;
      rdn_d        <= 1'b1;
      row_d        <= 9'd0;
      col_d        <= 10'd0;
    end else begin
      rdn_d      <= rdn;
      row_d      <= row;
      col_d      <= col;
      wr_ack     <= 1'b0;
      clear_done <= 1'b0;
      swap_done  <= swap_fire;

      if (swap_fire) front <= ~front;

      // A new request in the swap cycle is kept for the following frame.
      if (swap_req)       swap_pending <= 1'b1;
      else if (swap_fire) swap_pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            clr_color <= clear_color;
            clr_addr  <= '0;
            busy      <= 1'b1;
            state     <= ST_CLEAR;
          end else if (wr_req) begin
            wr_ack <= 1'b1;
            if (!wr_in_range) wr_err <= 1'b1;
            state  <= ST_ACK;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        ST_CLEAR: begin
          if (clr_addr == AW'(DEPTH - 1)) begin
            busy       <= 1'b0;
            clear_done <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_server.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_server
//
// Directed bench for vga_frame_server. A source-pixel model of both banks
// (unknown entries held as -1) plus the front/pending/error state is updated
// at transaction level by the driver tasks; one negedge process compares pix
// against the model every cycle, and the tasks check handshake timing and
// a set of hand-computed pixel values.
// -----------------------------------------------------------------------------
module tb_vga_frame_server;

  localparam int FB_W  = 160;
  localparam int FB_H  = 120;
  localparam int DEPTH = FB_W * FB_H;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  row;
  logic [9:0]  col;
  logic        rdn;
  logic [11:0] pix;
  logic        wr_req;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        wr_err;
  logic        clear_req;
  logic [11:0] clear_color;
  logic        busy;
  logic        clear_done;
  logic        swap_req;
  logic        swap_done;

  always #50 clk = ~clk;

  vga_frame_server dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .rdn(rdn), .pix(pix),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .clear_req(clear_req),
    .clear_color(clear_color), .busy(busy), .clear_done(clear_done),
    .swap_req(swap_req), .swap_done(swap_done)
  );

  // ---------------------------------------------------------------------------
  // Model and score
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int mb [2][DEPTH];
  int m_front   = 0;
  bit m_pending = 1'b0;
  bit m_err     = 1'b0;
  bit m_clearing = 1'b0;
  bit chk_en    = 1'b0;
  bit sweeping  = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic int exp_pix();
    if (rdn !== 1'b0 || row >= 9'd480 || col >= 10'd640) return 0;
    return mb[m_front][(int'(row) / 4) * FB_W + int'(col) / 4];
  endfunction

  always @(negedge clk) begin
    int e;
    if (chk_en && !sweeping && !rst) begin
      e = exp_pix();
      if (e >= 0) begin
        total++;
        if (pix !== e[11:0]) begin
          bad++;
          $display("FAIL pix_model row=%0d col=%0d: got 0x%0h, want 0x%0h",
                   row, col, pix, e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_model(input int bank, input int v);
    for (int a = 0; a < DEPTH; a++) mb[bank][a] = v;
  endtask

  // Single CPU write with the request held one cycle past the ack.
  task automatic do_write(input int x, input int y, input logic [11:0] d, input string name);
    int n = 0;
    int ack_at = -1;
    bit in_rng;
    in_rng  = (x < FB_W) && (y < FB_H);
    wr_x    = 8'(x);
    wr_y    = 7'(y);
    wr_data = d;
    wr_req  = 1'b1;
    while (n < 8 && ack_at < 0) begin
      @(negedge clk);
      n++;
      if (wr_ack) ack_at = n;
    end
    check({name, "_ack_latency"}, ack_at, 2);
    @(negedge clk);
    check({name, "_ack_width"}, int'(wr_ack), 0);
    #1 wr_req = 1'b0;
    @(negedge clk);
    check({name, "_no_reaccept"}, int'(wr_ack), 0);
    if (in_rng) mb[1 - m_front][y * FB_W + x] = int'(d);
    else m_err = 1'b1;
    check({name, "_wr_err"}, int'(wr_err), int'(m_err));
    step();
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req  = 1'b0;
    m_pending = 1'b1;
  endtask

  // Last visible pixel read, then one idle cycle: that idle cycle is the
  // frame end.
  task automatic frame_end(input string name);
    bit exp_sw;
    int cnt = 0;
    int at  = -1;
    exp_sw = m_pending && !m_clearing;
    rdn = 1'b0; row = 9'd479; col = 10'd639;
    step();
    rdn = 1'b1; row = 9'd0; col = 10'd0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (swap_done) begin cnt++; if (at < 0) at = i; end
      #1;
      if (i == 1 && exp_sw) begin
        m_front   = 1 - m_front;
        m_pending = 1'b0;
      end
    end
    check({name, "_swap_count"}, cnt, exp_sw ? 1 : 0);
    if (exp_sw) check({name, "_swap_cycle"}, at, 2);
    step();
  endtask

  task automatic rd(input int r, input int c, input int expv, input string name);
    rdn = 1'b0; row = 9'(r); col = 10'(c);
    @(negedge clk);
    check(name, int'(pix), expv);
    step();
    rdn = 1'b1; row = 9'd0; col = 10'd0;
  endtask

  // Read every source pixel of the front bank with varying sub-pixel offsets.
  task automatic sweep(input string name);
    int nbad  = 0;
    int first = -1;
    int f;
    int e;
    f = m_front;
    sweeping = 1'b1;
    for (int y = 0; y < FB_H; y++) begin
      for (int x = 0; x < FB_W; x++) begin
        row = 9'(y * 4 + ((x + y) & 3));
        col = 10'(x * 4 + ((3 * x + y) & 3));
        rdn = 1'b0;
        #1;
        e = mb[f][y * FB_W + x];
        if (e >= 0 && pix !== e[11:0]) begin
          nbad++;
          if (first < 0) first = y * FB_W + x;
        end
      end
    end
    rdn = 1'b1; row = 9'd0; col = 10'd0;
    step();
    sweeping = 1'b0;
    if (nbad != 0) $display("first bad source address %0d", first);
    check(name, nbad, 0);
  endtask

  // Bulk clear of the back bank. Optional: a write request raised at cycle
  // wr_at, a reset at cycle rst_at, a swap request plus frame end at fe_at.
  task automatic run_clear(input logic [11:0] color, input int wr_at, input int rst_at,
                           input int fe_at, input string name);
    int n = 0;
    int busy_cycles = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int fall_cyc = -1;
    int ack_cyc  = -1;
    int sw_cnt   = 0;
    int back;
    back = 1 - m_front;
    clear_color = color;
    clear_req   = 1'b1;
    step();
    clear_req   = 1'b0;
    clear_color = 12'h000;
    m_clearing  = 1'b1;
    while (n < 20100) begin
      @(negedge clk);
      n++;
      if (busy) busy_cycles++;
      else if (fall_cyc < 0) fall_cyc = n;
      if (clear_done) begin done_cnt++; done_cyc = n; end
      if (swap_done) sw_cnt++;
      if (wr_ack && ack_cyc < 0) ack_cyc = n;
      #1;
      if (wr_ack) wr_req = 1'b0;
      if (wr_at > 0 && n == wr_at) begin
        wr_x = 8'd5; wr_y = 7'd5; wr_data = 12'hABC; wr_req = 1'b1;
      end
      if (rst_at > 0 && n == rst_at) begin
        rst = 1'b1;
        m_front = 0; m_pending = 1'b0; m_err = 1'b0;
        fill_model(1, -1);
        fill_model(0, -1);
      end
      if (rst_at > 0 && n == rst_at + 1) rst = 1'b0;
      if (fe_at > 0) begin
        if (n == fe_at) swap_req = 1'b1;
        if (n == fe_at + 1) begin
          swap_req = 1'b0; m_pending = 1'b1;
          rdn = 1'b0; row = 9'd479; col = 10'd639;
        end
        if (n == fe_at + 2) begin
          rdn = 1'b1; row = 9'd0; col = 10'd0;
        end
      end
      if (fall_cyc > 0 && n >= fall_cyc + 3) break;
    end
    wr_req = 1'b0;
    m_clearing = 1'b0;
    if (rst_at > 0) begin
      check({name, "_busy_drop_after_rst"}, fall_cyc, rst_at + 1);
      check({name, "_no_done_after_rst"}, done_cnt, 0);
    end else begin
      check({name, "_busy_cycles"}, busy_cycles, 19200);
      check({name, "_done_count"}, done_cnt, 1);
      check({name, "_done_cycle"}, done_cyc, fall_cyc);
      fill_model(back, int'(color));
    end
    if (wr_at > 0) begin
      check({name, "_ack_after_busy"}, ack_cyc, fall_cyc + 1);
      mb[back][5 * FB_W + 5] = 'hABC;
    end
    if (fe_at > 0) check({name, "_no_swap_in_clear"}, sw_cnt, 0);
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    fill_model(0, -1);
    fill_model(1, -1);
    rst = 1'b1; rdn = 1'b1; row = 9'd0; col = 10'd0;
    wr_req = 1'b0; wr_x = 8'd0; wr_y = 7'd0; wr_data = 12'h000;
    clear_req = 1'b0; clear_color = 12'h000; swap_req = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr_ack", int'(wr_ack), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_swap_done", int'(swap_done), 0);
    check("rst_clear_done", int'(clear_done), 0);
    check("rst_wr_err", int'(wr_err), 0);
    check("rst_pix_rdn_high", int'(pix), 0);
    step();
    // Out-of-window reads give black regardless of bank contents.
    rdn = 1'b0; row = 9'd480; col = 10'd0;   #1 check("pix_row480", int'(pix), 0);
    row = 9'd0; col = 10'd640;               #1 check("pix_col640", int'(pix), 0);
    row = 9'd511; col = 10'd1023;            #1 check("pix_max_addr", int'(pix), 0);
    rdn = 1'b1; row = 9'd0; col = 10'd0;
    step();
    chk_en = 1'b1;

    // Clear bank 1 with a write request raised mid-clear.
    run_clear(12'h123, 100, 0, 0, "clr1");

    // Pixel write and out-of-range writes into bank 1.
    do_write(3, 2, 12'hF0A, "wr_3_2");
    do_write(160, 0, 12'hFFF, "wr_x160");
    do_write(0, 120, 12'hEEE, "wr_y120");

    // Swap so bank 1 is displayed.
    pulse_swap();
    frame_end("swap1");
    for (int r = 8; r <= 11; r++)
      for (int c = 12; c <= 15; c++)
        rd(r, c, 'hF0A, "px_F0A");
    rd(8, 16, 'h123, "px_clear_right");
    rd(7, 12, 'h123, "px_clear_above");
    rd(20, 23, 'hABC, "px_mid_clear_write");
    rd(479, 639, 'h123, "px_last");
    sweep("sweep_bank1");

    // Clear bank 0 with a swap request and frame end during the clear.
    run_clear(12'h456, 0, 0, 300, "clr0");
    frame_end("swap_deferred");
    frame_end("swap_once");
    rd(0, 0, 'h456, "px_bank0_origin");
    sweep("sweep_bank0");

    // Reset in the middle of a clear, then a full clear from address 0.
    run_clear(12'h789, 0, 5000, 0, "clr_rst");
    check("wr_err_cleared_by_rst", int'(wr_err), 0);
    run_clear(12'hAAA, 0, 0, 0, "clr_restart");
    pulse_swap();
    frame_end("swap2");
    rd(100, 200, 'hAAA, "px_after_restart");
    sweep("sweep_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #9000000;
    bad++;
    $display("FAIL watchdog: got timeout, want test end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_frame_server.md
Name: vga_frame_server

Overview:
Pixel-source responder for the VGA display timing unit. It answers the display's row/col/rdn read requests with 12-bit colour from a double-buffered 160x120 frame store, scaled 4x to 640x480. It accepts CPU-side pixel writes and bulk clears into the back buffer through a req/ack handshake. Buffer swaps happen only at end-of-frame, so the display never shows a half-drawn frame.

Parameters:
FB_W, 160, frame-store width in source pixels
FB_H, 120, frame-store height in source pixels
SCALE_SH, 2, log2 of the display scale factor (4x)

Ports:
clk  in  1  system clock, same domain as display timing
rst  in  1  synchronous active-high reset
row  in  9  display row address, 0..479 valid
col  in  10  display column address, 0..639 valid
rdn  in  1  active-low display read strobe
pix  out  12  colour {B[11:8],G[7:4],R[3:0]}, combinational
wr_req  in  1  CPU write request, level, held until wr_ack
wr_x  in  8  write x, 0..FB_W-1
wr_y  in  7  write y, 0..FB_H-1
wr_data  in  12  write colour
wr_ack  out  1  one-cycle write-accepted pulse
wr_err  out  1  sticky; set on an out-of-range write, cleared by rst
clear_req  in  1  request to fill the back buffer with clear_color
clear_color  in  12  fill colour, sampled on the clear start cycle
busy  out  1  high while a clear is in progress
clear_done  out  1  one-cycle pulse after the last clear write
swap_req  in  1  one-cycle pulse requesting a front/back swap
swap_done  out  1  one-cycle pulse in the cycle after the swap

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: front=0, swap_pending=0, state=IDLE, wr_ack=0, wr_err=0, busy=0, clear_done=0, swap_done=0. Memory contents are not reset.
- Storage: two banks of FB_W*FB_H x 12 bits. Address = y*FB_W + x. Display reads are asynchronous.
- Display read: pix = bank[front][(row>>SCALE_SH)*FB_W + (col>>SCALE_SH)] when rdn=0, row<480 and col<640; otherwise 12'h000. Latency is zero (combinational).
- CPU side always targets bank[~front].
- FSM states are IDLE, ACK and CLEAR.
  - IDLE, clear_req=1 (takes priority over wr_req): latch clear_color, clr_addr<=0, go to CLEAR, busy<=1.
  - IDLE, wr_req=1: if in range, write at this edge; if out of range, do not write and set wr_err. Either way wr_ack<=1 and go to ACK.
  - ACK: wr_ack<=0, return to IDLE. wr_req is ignored here, so there is at most one write per 2 cycles and a held request is not double-accepted.
  - CLEAR: write clear colour at clr_addr and increment. At clr_addr==FB_W*FB_H-1, write it, then go to IDLE with busy<=0 and clear_done<=1 for 1 cycle. A full clear takes 19200 cycles.
  - In CLEAR, wr_req and clear_req are ignored; requests stall without ack until IDLE.
- Frame-end event (fe): registered rdn_d, row_d, col_d; fe = rdn & ~rdn_d & (row_d==479) & (col_d==639), i.e. the first non-read cycle after the last visible pixel.
- swap_req sets swap_pending. A swap_req arriving in the same cycle as a swap leaves pending set for the next frame.
- Swap: on fe with swap_pending=1 and state!=CLEAR, toggle front, clear swap_pending, and pulse swap_done next cycle. If in CLEAR, defer to the next fe with pending kept.
- A write committed on the same edge as the swap lands in the pre-swap back bank, i.e. the new front.
- rst mid-clear or mid-handshake: FSM returns to IDLE immediately, a partially cleared bank is left as is, and no ack or done pulse is issued.

Test Plan:
- rst 2 cycles -> front=0, wr_ack=busy=swap_done=clear_done=wr_err=0; pix=0 while rdn=1.
- wr_req with x=3, y=2, data=12'hF0A held -> wr_ack high exactly 1 cycle, one cycle after the request. Then swap_req and run a frame -> swap_done after row 479/col 639. With rdn=0, row 8..11 and col 12..15 read 12'hF0A, and row 8/col 16 reads the clear value.
- Write x=160 -> wr_ack pulses, wr_err=1 sticky, no bank changes (checked by reading all addresses after swap).
- clear_req with clear_color=12'h123 -> busy for 19200 cycles, clear_done 1 pulse. A wr_req issued mid-clear is acked only after busy falls.
- swap_req during a clear spanning fe -> no swap at that fe, swap at the next fe, swap_done once.
- rst asserted at clear cycle 5000 -> busy=0 next cycle, no clear_done. A new clear_req then restarts from address 0.
